mem_bram_resp: RTL and testbench

// - Responder (memory side) of the shared-memory client protocol used by tft, rectfill, ppu_fb and mem_test.
// - Serves IN clients from on-chip block RAM using the same req/ack/valid handshake and BURST read semantics as the SDRAM path.
// - Use: scratch memory for small buffers, and a drop-in memory model for client-level benches without the SDRAM controller.

---
 rtl/mem_bram_resp_pkg.sv | 20 ++
 rtl/mem_bram_resp_if.sv | 19 +
 rtl/mem_bram_resp_rr_arbiter.sv | 25 ++
 rtl/mem_bram_resp.sv | 173 +++++++++++++++++
 tb/tb_mem_bram_resp.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bram_resp_pkg.sv
// rtl/mem_bram_resp_pkg.sv - shared client request type and responder FSM states
package mem_bram_resp_pkg;

  localparam int MEM_AN = 24;
  localparam int MEM_DN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [MEM_AN-1:0] addr;
    logic [MEM_DN-1:0] data;
    logic              wr;
  } mem_req_t;

endpackage

// File: rtl/mem_bram_resp_if.sv
// rtl/mem_bram_resp_if.sv - shared-memory client bus between IN clients and one responder
interface mem_bram_resp_if #(
  parameter int AN = 24,
  parameter int DN = 16,
  parameter int IN = 4
) ();

  logic [AN-1:0] addr [IN];
  logic [DN-1:0] data [IN];
  logic [IN-1:0] wr;
  logic [IN-1:0] req;
  logic [IN-1:0] ack;
  logic [DN-1:0] data_out;
  logic [IN-1:0] valid;

  modport master (output addr, data, wr, req, input ack, data_out, valid);
  modport slave  (input addr, data, wr, req, output ack, data_out, valid);

endinterface

// File: rtl/mem_bram_resp_rr_arbiter.sv
// rtl/mem_bram_resp_rr_arbiter.sv - combinational round-robin grant, first requester after ptr
module mem_bram_resp_rr_arbiter #(
  parameter int IN = 4,
  localparam int PW = (IN > 1) ? $clog2(IN) : 1
) (
  input  logic [IN-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [IN-1:0] gnt
);

  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the client closest after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = IN; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % IN);
      if (req[idx]) begin
        gnt = IN'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/mem_bram_resp.sv
// rtl/mem_bram_resp.sv - block-RAM responder for the shared-memory client protocol
module mem_bram_resp
  import mem_bram_resp_pkg::*;
#(
  parameter int            AN    = MEM_AN,
  parameter int            DN    = MEM_DN,
  parameter int            IN    = 4,
  parameter int            BURST = 8,
  parameter int            MAN   = 12,
  parameter logic [AN-1:0] BASE  = '0
) (
  input  logic           clkSYS,
  input  logic           reset,
  mem_bram_resp_if.slave bus,
  output logic           busy,
  output logic [7:0]     err_cnt
);

  localparam int PW = (IN > 1) ? $clog2(IN) : 1;
  localparam int CW = $clog2(BURST) + 1;

  mem_state_e     state_q, state_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [IN-1:0]  ack_q, ack_d;
  logic [MAN-1:0] raddr_q, raddr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           miss_q, miss_d;
  logic [IN-1:0]  owner_q, owner_d;
  logic [7:0]     err_q, err_d;
  logic           rd_vld_q, rd_vld_d;
  logic           rd_miss_q, rd_miss_d;
  logic [IN-1:0]  rd_owner_q, rd_owner_d;
  logic [IN-1:0]  valid_q, valid_d;
  logic [DN-1:0]  data_out_q, data_out_d;
  logic [DN-1:0]  rd_data_q;

  logic [DN-1:0]  mem [2**MAN];

  logic [IN-1:0]  gnt;
  logic [PW-1:0]  g_idx;
  logic           grant_en;
  logic           in_win;
  logic           mem_we;
  logic           rd_issue;
  logic [MAN-1:0] rd_addr;
  mem_req_t       sel;

  mem_bram_resp_rr_arbiter #(.IN(IN)) u_arb (
    .req (bus.req),
    .ptr (rr_q),
    .gnt (gnt)
  );

  // Decode the winning client and look at its request
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < IN; i++) begin
      if (gnt[i]) g_idx = PW'(i);
    end
    sel.addr = bus.addr[g_idx];
    sel.data = bus.data[g_idx];
    sel.wr   = bus.wr[g_idx];
    grant_en = (state_q == ST_IDLE) && (|bus.req);
    in_win   = (sel.addr[AN-1:MAN] == BASE[AN-1:MAN]);
    mem_we   = grant_en && sel.wr && in_win && !reset;
  end

  // Next-state logic: writes take a dead TURN cycle, reads issue BURST words then DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          if (sel.wr)          state_d = ST_TURN;
          else if (BURST == 1) state_d = ST_DRAIN;
          else                 state_d = ST_READ;
        end
      end
      ST_TURN:  state_d = ST_IDLE;
      ST_READ:  if (cnt_q == CW'(BURST - 1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: the first read is issued on the grant edge so valid lands two cycles after req
  always_comb begin
    ack_d      = '0;
    rr_d       = rr_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    miss_d     = miss_q;
    owner_d    = owner_q;
    err_d      = err_q;
    rd_issue   = (state_q == ST_READ);
    rd_addr    = raddr_q + MAN'(cnt_q);
    rd_miss_d  = miss_q;
    rd_owner_d = owner_q;
    if (grant_en) begin
      ack_d = gnt;
      rr_d  = g_idx;
      if (!in_win && err_q != 8'hFF) err_d = err_q + 8'd1;
      if (!sel.wr) begin
        raddr_d    = sel.addr[MAN-1:0];
        cnt_d      = CW'(1);
        miss_d     = !in_win;
        owner_d    = gnt;
        rd_issue   = 1'b1;
        rd_addr    = sel.addr[MAN-1:0];
        rd_miss_d  = !in_win;
        rd_owner_d = gnt;
      end
    end
    if (state_q == ST_READ) cnt_d = cnt_q + CW'(1);
    rd_vld_d   = rd_issue;
    valid_d    = rd_vld_q ? rd_owner_q : '0;
    data_out_d = data_out_q;
    if (rd_vld_q) data_out_d = rd_miss_q ? '0 : rd_data_q;
  end

  // Outputs are straight from registers
  always_comb begin
    busy         = (state_q != ST_IDLE);
    err_cnt      = err_q;
    bus.ack      = ack_q;
    bus.valid    = valid_q;
    bus.data_out = data_out_q;
  end

  // FSM state register
  always_ff @(posedge clkSYS) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Control and output registers; reset abandons any burst in flight
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      rr_q       <= PW'(IN - 1);
      ack_q      <= '0;
      raddr_q    <= '0;
      cnt_q      <= '0;
      miss_q     <= 1'b0;
      owner_q    <= '0;
      err_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_owner_q <= '0;
      valid_q    <= '0;
      data_out_q <= '0;
    end else begin
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      rd_miss_q  <= rd_miss_d;
      rd_owner_q <= rd_owner_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  // Single-port BRAM with registered read; contents survive reset
  always_ff @(posedge clkSYS) begin
    if (mem_we) mem[sel.addr[MAN-1:0]] <= sel.data;
    if (rd_issue) rd_data_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_mem_bram_resp.sv
// tb/tb_mem_bram_resp.sv - directed self-checking bench for mem_bram_resp
module tb_mem_bram_resp;

  localparam int AN = 24;
  localparam int DN = 16;
  localparam int IN = 4;
  localparam int BURST = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [7:0] err_cnt;

  mem_bram_resp_if #(.AN(AN), .DN(DN), .IN(IN)) bus ();

  mem_bram_resp #(.AN(AN), .DN(DN), .IN(IN), .BURST(BURST), .MAN(12), .BASE(24'h0)) dut (
    .clkSYS  (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DN-1:0] rd_words [16];
  int rd_cnt, ack_n, first_n, last_n, ack_total;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req = '0;
    bus.wr  = '0;
    for (int i = 0; i < IN; i++) begin
      bus.addr[i] = '0;
      bus.data[i] = '0;
    end
  endtask

  task automatic do_write(input int c, input logic [AN-1:0] a, input logic [DN-1:0] d, output int acks);
    bus.addr[c] = a;
    bus.data[c] = d;
    bus.wr[c]   = 1'b1;
    bus.req[c]  = 1'b1;
    acks = 0;
    for (int n = 0; n < 20 && acks == 0; n++) begin
      tick();
      if (bus.ack[c]) acks++;
    end
    bus.req[c] = 1'b0;
    bus.wr[c]  = 1'b0;
    tick();
    if (bus.ack[c]) acks++;
  endtask

  task automatic do_read(input int c, input logic [AN-1:0] a);
    bus.addr[c] = a;
    bus.wr[c]   = 1'b0;
    bus.req[c]  = 1'b1;
    rd_cnt = 0; ack_n = -1; first_n = -1; last_n = -1; ack_total = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (bus.ack[c]) begin
        ack_total++;
        if (ack_n < 0) ack_n = n;
        bus.req[c] = 1'b0;
      end
      if (bus.valid[c]) begin
        if (rd_cnt < 16) rd_words[rd_cnt] = bus.data_out;
        rd_cnt++;
        if (first_n < 0) first_n = n;
        last_n = n;
      end
    end
    bus.req[c] = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (bus.ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    n_cmp++; if (bus.valid !== 4'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0000", bus.valid); end
    n_cmp++; if (bus.data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data_out: got %h expected 0000", bus.data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int acks, sum;
    sum = 0;
    for (int i = 1; i < 8; i++) begin
      do_write(1, 24'h000010 + AN'(i), 16'h1100 + DN'(i), acks);
      sum += acks;
    end
    n_cmp++; if (sum !== 7) begin n_bad++; $display("FAIL wr_prefill_acks: got %0d expected 7", sum); end
    do_write(1, 24'h000010, 16'hA5A5, acks);
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL wr_ack_once: got %0d expected 1", acks); end
    do_read(1, 24'h000010);
    n_cmp++; if (ack_total !== 1) begin n_bad++; $display("FAIL rd_ack_once: got %0d expected 1", ack_total); end
    n_cmp++; if (ack_n !== 1) begin n_bad++; $display("FAIL rd_ack_cycle: got %0d expected 1", ack_n); end
    n_cmp++; if (first_n !== 2) begin n_bad++; $display("FAIL rd_first_valid: got %0d expected 2", first_n); end
    n_cmp++; if (last_n !== 9) begin n_bad++; $display("FAIL rd_last_valid: got %0d expected 9", last_n); end
    n_cmp++; if (rd_cnt !== 8) begin n_bad++; $display("FAIL rd_count: got %0d expected 8", rd_cnt); end
    n_cmp++; if (rd_words[0] !== 16'hA5A5) begin n_bad++; $display("FAIL rd_word0: got %h expected a5a5", rd_words[0]); end
    for (int i = 1; i < 8; i++) begin
      n_cmp++;
      if (rd_words[i] !== 16'h1100 + DN'(i)) begin
        n_bad++; $display("FAIL rd_word%0d: got %h expected %h", i, rd_words[i], 16'h1100 + DN'(i));
      end
    end
    n_cmp++; if (bus.data_out !== 16'h1107) begin n_bad++; $display("FAIL data_out_hold: got %h expected 1107", bus.data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_window_wrap();
    int acks;
    for (int k = 0; k < 8; k++) begin
      do_write(0, (24'h000FFC + AN'(k)) & 24'h000FFF, 16'hC000 + DN'(k), acks);
    end
    do_read(0, 24'h000FFC);
    n_cmp++; if (rd_cnt !== 8) begin n_bad++; $display("FAIL wrap_count: got %0d expected 8", rd_cnt); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rd_words[k] !== 16'hC000 + DN'(k)) begin
        n_bad++; $display("FAIL wrap_word%0d: got %h expected %h", k, rd_words[k], 16'hC000 + DN'(k));
      end
    end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL wrap_err_cnt: got %h expected 00", err_cnt); end
  endtask

  task automatic test_out_of_window();
    int acks;
    do_write(0, 24'h001000, 16'h1234, acks);
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL oow_wr_ack: got %0d expected 1", acks); end
    do_read(0, 24'h001000);
    n_cmp++; if (ack_total !== 1) begin n_bad++; $display("FAIL oow_rd_ack: got %0d expected 1", ack_total); end
    n_cmp++; if (rd_cnt !== 8) begin n_bad++; $display("FAIL oow_count: got %0d expected 8", rd_cnt); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rd_words[k] !== 16'h0) begin n_bad++; $display("FAIL oow_word%0d: got %h expected 0000", k, rd_words[k]); end
    end
    n_cmp++; if (err_cnt !== 8'h02) begin n_bad++; $display("FAIL oow_err_cnt: got %h expected 02", err_cnt); end
    do_read(0, 24'h000000);
    n_cmp++; if (rd_words[0] !== 16'hC004) begin n_bad++; $display("FAIL oow_mem0: got %h expected c004", rd_words[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int nv;
    bool_done: begin end
    bus.addr[3] = 24'h000010;
    bus.wr[3]   = 1'b0;
    bus.req[3]  = 1'b1;
    nv = 0;
    for (int n = 1; n <= 16 && nv < 3; n++) begin
      tick();
      if (bus.ack[3]) bus.req[3] = 1'b0;
      if (bus.valid[3]) nv++;
    end
    n_cmp++; if (nv !== 3) begin n_bad++; $display("FAIL mid_reach_3rd: got %0d expected 3", nv); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.valid !== 4'b0) begin n_bad++; $display("FAIL mid_valid: got %b expected 0000", bus.valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL mid_err_cnt: got %h expected 00", err_cnt); end
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.valid !== 4'b0) begin n_bad++; $display("FAIL mid_no_resume: got %b expected 0000", bus.valid); end
    do_read(3, 24'h000010);
    n_cmp++; if (rd_cnt !== 8) begin n_bad++; $display("FAIL mid_reread_count: got %0d expected 8", rd_cnt); end
    n_cmp++; if (rd_words[0] !== 16'hA5A5) begin n_bad++; $display("FAIL mid_reread_word0: got %h expected a5a5", rd_words[0]); end
    n_cmp++; if (rd_words[1] !== 16'h1101) begin n_bad++; $display("FAIL mid_reread_word1: got %h expected 1101", rd_words[1]); end
  endtask

  task automatic test_contention();
    int order [5];
    int cyc [5];
    int k, idx;
    clear_reqs();
    reset = 1'b1;
    for (int i = 0; i < IN; i++) begin
      bus.addr[i] = 24'h000040 + AN'(i);
      bus.data[i] = 16'h4000 + DN'(i);
      bus.wr[i]   = 1'b1;
    end
    bus.req = 4'b1111;
    repeat (2) tick();
    reset = 1'b0;
    k = 0;
    for (int n = 1; n <= 20 && k < 5; n++) begin
      tick();
      if (bus.ack !== 4'b0) begin
        n_cmp++;
        if (!$onehot(bus.ack)) begin n_bad++; $display("FAIL cont_onehot: got %b expected one-hot", bus.ack); end
        idx = 0;
        for (int i = 0; i < IN; i++) if (bus.ack[i]) idx = i;
        order[k] = idx;
        cyc[k] = n;
        k++;
      end
    end
    clear_reqs();
    repeat (3) tick();
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL cont_grants: got %0d expected 5", k); end
    for (int j = 0; j < 5 && j < k; j++) begin
      n_cmp++;
      if (order[j] !== (j % 4)) begin n_bad++; $display("FAIL cont_order%0d: got %0d expected %0d", j, order[j], j % 4); end
      if (j > 0) begin
        n_cmp++;
        if (cyc[j] - cyc[j-1] !== 2) begin
          n_bad++; $display("FAIL cont_spacing%0d: got %0d expected 2", j, cyc[j] - cyc[j-1]);
        end
      end
    end
  endtask

  task automatic test_held_req();
    int acks, seen;
    bus.addr[2] = 24'h000020;
    bus.data[2] = 16'h7777;
    bus.wr[2]   = 1'b1;
    bus.req[2]  = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      tick();
      if (bus.ack[2]) seen = 1;
    end
    n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL held_first_ack: got %0d expected 1", seen); end
    bus.data[2] = 16'h8888;
    tick();
    acks = 0;
    if (bus.ack[2]) acks++;
    bus.req[2] = 1'b0;
    bus.wr[2]  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.ack !== 4'b0) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL held_extra_ack: got %0d expected 0", acks); end
    do_read(2, 24'h000020);
    n_cmp++; if (rd_words[0] !== 16'h7777) begin n_bad++; $display("FAIL held_one_write: got %h expected 7777", rd_words[0]); end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_write_read();
    test_window_wrap();
    test_out_of_window();
    test_reset_mid_burst();
    test_contention();
    test_held_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
